// File: rtl/health_manager_if.sv
// -----------------------------------------------------------------------------
// health_manager_if
//   Bundles the frame-rate event inputs and the status/display outputs of
//   health_manager into a single port.
//   The parameters must match the ones used on the health_manager instance.
//
//   Event side (driven by the game logic, master -> slave):
//     frame_tick   one-cycle strobe; events are sampled only on this strobe
//     hit_valid    damage request
//     hit_amount   damage points
//     heal_valid   heal request
//     heal_amount  heal points
//     restart      level-sensitive restart request
//
//   Status side (driven by health_manager, slave -> master):
//     health       current health value (registered)
//     invuln       high while invulnerable
//     game_over    high while dead
//     hit_ack      one-cycle pulse when a hit is accepted
//     hex_tens     active-low 7-segment pattern for the tens digit, {g..a}
//     hex_ones     active-low 7-segment pattern for the ones digit, {g..a}
// -----------------------------------------------------------------------------
interface health_manager_if #(
  parameter int HEALTH_W = 7,
  parameter int DMG_W    = 4
);
  logic                frame_tick;
  logic                hit_valid;
  logic [DMG_W-1:0]    hit_amount;
  logic                heal_valid;
  logic [DMG_W-1:0]    heal_amount;
  logic                restart;

  logic [HEALTH_W-1:0] health;
  logic                invuln;
  logic                game_over;
  logic                hit_ack;
  logic [6:0]          hex_tens;
  logic [6:0]          hex_ones;

  modport master (
    output frame_tick, hit_valid, hit_amount, heal_valid, heal_amount, restart,
    input  health, invuln, game_over, hit_ack, hex_tens, hex_ones
  );

  modport slave (
    input  frame_tick, hit_valid, hit_amount, heal_valid, heal_amount, restart,
    output health, invuln, game_over, hit_ack, hex_tens, hex_ones
  );
endinterface

// File: rtl/health_manager.sv
// -----------------------------------------------------------------------------
// health_manager
//   Player-health controller.
//   - Damage and healing are applied once per game frame (frame_tick).
//   - An accepted non-lethal hit starts a window of invulnerability.
//   - Reaching zero health latches game-over until restart.
//   - The two-digit 7-segment display pattern is derived from the health value.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high
//     bus    health_manager_if.slave
//            (frame events in; health, state and display out)
//
//   Optional feature: define HEALTH_REGEN_EN to enable regeneration.
//   - Health gains +1 after every REGEN_FRAMES frame ticks spent in ALIVE,
//     saturating at MAX_HEALTH.
//   - The regen count restarts on a hit, an invulnerable window, death or
//     restart.
//   - Without the macro, REGEN_FRAMES has no effect.
// -----------------------------------------------------------------------------
module health_manager #(
  parameter int MAX_HEALTH    = 10,   // 1..99
  parameter int HEALTH_W      = 7,    // must hold MAX_HEALTH + 2**DMG_W
  parameter int DMG_W         = 4,
  parameter int INVULN_FRAMES = 30,   // >= 1
  parameter int REGEN_FRAMES  = 120   // >= 1
) (
  input  logic            clk,
  input  logic            reset,
  health_manager_if.slave bus
);

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } state_t;

  localparam int TIMER_W = $clog2(INVULN_FRAMES + 1);

  localparam logic [HEALTH_W-1:0]      MAX_H       = HEALTH_W'(MAX_HEALTH);
  localparam logic signed [HEALTH_W:0] MAX_S       = (HEALTH_W+1)'(MAX_HEALTH);
  localparam logic [TIMER_W-1:0]       INVULN_INIT = TIMER_W'(INVULN_FRAMES);

  state_t              state_reg,   state_next;
  logic [HEALTH_W-1:0] health_reg,  health_next;
  logic [TIMER_W-1:0]  timer_reg,   timer_next;
  logic                hit_ack_reg, hit_ack_next;

`ifdef HEALTH_REGEN_EN
  localparam int REGEN_W = $clog2(REGEN_FRAMES + 1);
  localparam logic [REGEN_W-1:0] REGEN_LAST = REGEN_W'(REGEN_FRAMES - 1);
  logic [REGEN_W-1:0] regen_cnt_reg, regen_cnt_next;
`endif

  // Net health change for this frame.
  // Hits only count while ALIVE, so INVULN and DEAD see heal-only sums.
  // The extra sign bit lets a large hit go negative before clamping to zero.
  logic [DMG_W-1:0]           heal_eff;
  logic [DMG_W-1:0]           hit_eff;
  logic signed [HEALTH_W:0]   sum;
  logic [HEALTH_W-1:0]        clamped;

  always_comb begin
    heal_eff = bus.heal_valid ? bus.heal_amount : '0;
    hit_eff  = (bus.hit_valid && (state_reg == ALIVE)) ? bus.hit_amount : '0;
    sum      = $signed({1'b0, health_reg})
             + $signed((HEALTH_W+1)'(heal_eff))
             - $signed((HEALTH_W+1)'(hit_eff));
    if (sum < 0) begin
      clamped = '0;
    end else if (sum > MAX_S) begin
      clamped = MAX_H;
    end else begin
      clamped = sum[HEALTH_W-1:0];
    end
  end

  always_comb begin
    state_next   = state_reg;
    health_next  = health_reg;
    timer_next   = timer_reg;
    hit_ack_next = 1'b0;
`ifdef HEALTH_REGEN_EN
    regen_cnt_next = regen_cnt_reg;
`endif

    if (bus.restart) begin
      state_next  = ALIVE;
      health_next = MAX_H;
      timer_next  = '0;
`ifdef HEALTH_REGEN_EN
      regen_cnt_next = '0;
`endif
    end else if (bus.frame_tick) begin
      case (state_reg)
        ALIVE: begin
          if (bus.hit_valid) begin
            // A zero-point hit is still a hit: it is acknowledged and
            // starts invulnerability like any other non-lethal hit.
            hit_ack_next = 1'b1;
`ifdef HEALTH_REGEN_EN
            regen_cnt_next = '0;
`endif
            if (clamped == '0) begin
              state_next  = DEAD;
              health_next = '0;
            end else begin
              state_next  = INVULN;
              health_next = clamped;
              timer_next  = INVULN_INIT;
            end
          end else begin
            health_next = clamped;
`ifdef HEALTH_REGEN_EN
            if (regen_cnt_reg == REGEN_LAST) begin
              regen_cnt_next = '0;
              if (clamped < MAX_H) begin
                health_next = clamped + HEALTH_W'(1);
              end
            end else begin
              regen_cnt_next = regen_cnt_reg + REGEN_W'(1);
            end
`endif
          end
        end

        INVULN: begin
          health_next = clamped;
          timer_next  = timer_reg - TIMER_W'(1);
          if (timer_reg == TIMER_W'(1)) begin
            state_next = ALIVE;
          end
`ifdef HEALTH_REGEN_EN
          regen_cnt_next = '0;
`endif
        end

        DEAD: begin
          health_next = '0;
`ifdef HEALTH_REGEN_EN
          regen_cnt_next = '0;
`endif
        end

        default: begin
          state_next = ALIVE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ALIVE;
      health_reg  <= MAX_H;
      timer_reg   <= '0;
      hit_ack_reg <= 1'b0;
`ifdef HEALTH_REGEN_EN
      regen_cnt_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      health_reg  <= health_next;
      timer_reg   <= timer_next;
      hit_ack_reg <= hit_ack_next;
`ifdef HEALTH_REGEN_EN
      regen_cnt_reg <= regen_cnt_next;
`endif
    end
  end

  assign bus.health    = health_reg;
  assign bus.invuln    = (state_reg == INVULN);
  assign bus.game_over = (state_reg == DEAD);
  assign bus.hit_ack   = hit_ack_reg;

  // Display: digit[0] = ones, digit[1] = tens. Health never exceeds 99.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [3:0] digit [2];
  logic [6:0] hex   [2];

  assign digit[0] = 4'(health_reg % HEALTH_W'(10));
  assign digit[1] = 4'(health_reg / HEALTH_W'(10));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_digit
      assign hex[gi] = seg7(digit[gi]);
    end
  endgenerate

  assign bus.hex_ones = hex[0];
  assign bus.hex_tens = hex[1];

endmodule

// File: tb/tb_health_manager.sv
// -----------------------------------------------------------------------------
// tb_health_manager
//   Directed bench for health_manager in its default build
//   (MAX_HEALTH=10, INVULN_FRAMES=30, regeneration disabled).
//   Each frame() call drives one clock cycle of inputs. Results are checked
//   1 time unit after the capturing clock edge.
// -----------------------------------------------------------------------------
module tb_health_manager;

  localparam logic [6:0] SEG0 = 7'b1000000;
  localparam logic [6:0] SEG1 = 7'b1111001;
  localparam logic [6:0] SEG2 = 7'b0100100;
  localparam logic [6:0] SEG7 = 7'b1111000;
  localparam logic [6:0] SEG8 = 7'b0000000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  health_manager_if #(.HEALTH_W(7), .DMG_W(4)) bus ();

  health_manager #(
    .MAX_HEALTH   (10),
    .HEALTH_W     (7),
    .DMG_W        (4),
    .INVULN_FRAMES(30),
    .REGEN_FRAMES (120)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.frame_tick  = 1'b0;
    bus.hit_valid   = 1'b0;
    bus.hit_amount  = 4'd0;
    bus.heal_valid  = 1'b0;
    bus.heal_amount = 4'd0;
    bus.restart     = 1'b0;
  endtask

  // One clock cycle of stimulus; returns 1 time unit after the capturing edge.
  task automatic frame(input logic tk, input logic hv, input int ha,
                       input logic lv, input int la, input logic rs);
    @(negedge clk);
    bus.frame_tick  = tk;
    bus.hit_valid   = hv;
    bus.hit_amount  = 4'(ha);
    bus.heal_valid  = lv;
    bus.heal_amount = 4'(la);
    bus.restart     = rs;
    @(posedge clk);
    #1;
    clear_inputs();
    $display("frame tick=%0b hit=%0b/%0d heal=%0b/%0d restart=%0b -> health=%0d invuln=%0b game_over=%0b hit_ack=%0b",
             tk, hv, ha, lv, la, rs, bus.health, bus.invuln, bus.game_over, bus.hit_ack);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_health",    int'(bus.health),    10);
    chk("reset_hex_tens",  int'(bus.hex_tens),  int'(SEG1));
    chk("reset_hex_ones",  int'(bus.hex_ones),  int'(SEG0));
    chk("reset_game_over", int'(bus.game_over), 0);
    chk("reset_invuln",    int'(bus.invuln),    0);
    chk("reset_hit_ack",   int'(bus.hit_ack),   0);
    @(negedge clk);
    reset = 1'b0;

    // Hit without a frame tick is ignored
    frame(1'b0, 1'b1, 3, 1'b0, 0, 1'b0);
    chk("notick_health",  int'(bus.health),  10);
    chk("notick_hit_ack", int'(bus.hit_ack), 0);

    // Hit 3 from 10 -> 7, acknowledged, invulnerable
    frame(1'b1, 1'b1, 3, 1'b0, 0, 1'b0);
    chk("hit3_health",   int'(bus.health),   7);
    chk("hit3_hit_ack",  int'(bus.hit_ack),  1);
    chk("hit3_invuln",   int'(bus.invuln),   1);
    chk("hit3_hex_tens", int'(bus.hex_tens), int'(SEG0));
    chk("hit3_hex_ones", int'(bus.hex_ones), int'(SEG7));

    // Invulnerable tick 1: hit 5 ignored, no ack
    frame(1'b1, 1'b1, 5, 1'b0, 0, 1'b0);
    chk("inv_hit_health",  int'(bus.health),  7);
    chk("inv_hit_hit_ack", int'(bus.hit_ack), 0);
    chk("inv_hit_invuln",  int'(bus.invuln),  1);

    // Invulnerable tick 2: heal 9 clamps at 10
    frame(1'b1, 1'b0, 0, 1'b1, 9, 1'b0);
    chk("inv_heal_health", int'(bus.health), 10);

    // Ticks 3..29 keep invulnerability, tick 30 drops it
    for (int i = 0; i < 27; i++) frame(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("inv_tick29_invuln", int'(bus.invuln), 1);
    frame(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("inv_tick30_invuln", int'(bus.invuln), 0);
    chk("inv_tick30_health", int'(bus.health), 10);

    // Hit 8 -> health 2, then wait out invulnerability
    frame(1'b1, 1'b1, 8, 1'b0, 0, 1'b0);
    chk("hit8_health",   int'(bus.health),   2);
    chk("hit8_hex_ones", int'(bus.hex_ones), int'(SEG2));
    for (int i = 0; i < 30; i++) frame(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("hit8_window_end_invuln", int'(bus.invuln), 0);

    // Health 2: hit 4 + heal 1 -> net -1 clamps to 0 -> DEAD
    frame(1'b1, 1'b1, 4, 1'b1, 1, 1'b0);
    chk("lethal_health",    int'(bus.health),    0);
    chk("lethal_game_over", int'(bus.game_over), 1);
    chk("lethal_hit_ack",   int'(bus.hit_ack),   1);
    chk("lethal_invuln",    int'(bus.invuln),    0);
    chk("lethal_hex_tens",  int'(bus.hex_tens),  int'(SEG0));
    chk("lethal_hex_ones",  int'(bus.hex_ones),  int'(SEG0));

    // DEAD ignores heal and hits
    frame(1'b1, 1'b0, 0, 1'b1, 5, 1'b0);
    chk("dead_heal_health",    int'(bus.health),    0);
    chk("dead_heal_game_over", int'(bus.game_over), 1);
    frame(1'b1, 1'b1, 1, 1'b0, 0, 1'b0);
    chk("dead_hit_hit_ack", int'(bus.hit_ack), 0);
    chk("dead_hit_health",  int'(bus.health),  0);

    // Restart for one cycle without a tick
    frame(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
    chk("restart_health",    int'(bus.health),    10);
    chk("restart_game_over", int'(bus.game_over), 0);
    chk("restart_invuln",    int'(bus.invuln),    0);

    // Simultaneous hit 5 + heal 3 from 10 -> 8
    frame(1'b1, 1'b1, 5, 1'b1, 3, 1'b0);
    chk("hitheal_health",   int'(bus.health),   8);
    chk("hitheal_invuln",   int'(bus.invuln),   1);
    chk("hitheal_hex_ones", int'(bus.hex_ones), int'(SEG8));

    // Restart while invulnerable clears the window
    frame(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
    chk("restart_inv_health", int'(bus.health), 10);
    chk("restart_inv_invuln", int'(bus.invuln), 0);

    // Heal at full health clamps in ALIVE
    frame(1'b1, 1'b0, 0, 1'b1, 5, 1'b0);
    chk("alive_heal_clamp_health", int'(bus.health), 10);

    // Zero-point hit: acknowledged and starts invulnerability
    frame(1'b1, 1'b1, 0, 1'b0, 0, 1'b0);
    chk("zero_hit_health",  int'(bus.health),  10);
    chk("zero_hit_hit_ack", int'(bus.hit_ack), 1);
    chk("zero_hit_invuln",  int'(bus.invuln),  1);
    frame(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);

    // Hit 15 from 10 clamps to 0 -> DEAD
    frame(1'b1, 1'b1, 15, 1'b0, 0, 1'b0);
    chk("overkill_health",    int'(bus.health),    0);
    chk("overkill_game_over", int'(bus.game_over), 1);
    frame(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);

    // Hit exactly equal to health -> DEAD
    frame(1'b1, 1'b1, 10, 1'b0, 0, 1'b0);
    chk("exact_hit_health",    int'(bus.health),    0);
    chk("exact_hit_game_over", int'(bus.game_over), 1);
    chk("exact_hit_hit_ack",   int'(bus.hit_ack),   1);
    frame(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);

    // Asynchronous reset takes effect without a clock edge
    frame(1'b1, 1'b1, 3, 1'b0, 0, 1'b0);
    chk("pre_async_health", int'(bus.health), 7);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_health", int'(bus.health), 10);
    chk("async_reset_invuln", int'(bus.invuln), 0);
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
